// File: rtl/det_event_logger_pkg.sv
// Shared constants, FIFO operation encoding and a log2 helper for the
// detection-episode logger.
package det_event_logger_pkg;

  localparam int TS_W_DEF  = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Encoding matches {push_accepted, pop_accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    while ((32'sd1 << res) < value) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/det_event_logger_sync_fifo.sv
// First-word-fall-through FIFO with synchronous clear; the head word and
// status flags are registered from next-state values.
module sync_fifo
  import det_event_logger_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = TS_W_DEF
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_wdata,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_full,
  output logic [clog2_f(DEPTH):0]   o_occ
);

  localparam int PTR_W = clog2_f(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_full;
  logic             r_valid;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_pop_ok;
  logic             w_push_ok;
  fifo_op_e         w_op;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Next-state pointers, occupancy and head word
  always_comb begin
    w_pop_ok     = i_pop & r_valid;
    // A pop frees a slot even when full, so push+pop on a full FIFO is legal
    w_push_ok    = i_push & (~r_full | w_pop_ok);
    w_op         = fifo_op_e'({w_push_ok, w_pop_ok});
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_occ_nxt    = r_occ;
    case (w_op)
      OP_IDLE: begin
      end
      OP_PUSH: begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        w_occ_nxt    = r_occ + OCC_W'(1);
      end
      OP_POP: begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        w_occ_nxt    = r_occ - OCC_W'(1);
      end
      OP_BOTH: begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      default: begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_occ_nxt    = r_occ;
      end
    endcase
    if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = i_wdata;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push_ok && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and registered outputs
  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr  <= {PTR_W{1'b0}};
      r_rd_ptr  <= {PTR_W{1'b0}};
      r_occ     <= {OCC_W{1'b0}};
      r_full    <= 1'b0;
      r_valid   <= 1'b0;
      r_rd_data <= {WIDTH{1'b0}};
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_occ     <= w_occ_nxt;
      r_full    <= (w_occ_nxt == OCC_W'(DEPTH));
      r_valid   <= (w_occ_nxt != {OCC_W{1'b0}});
      r_rd_data <= (w_occ_nxt != {OCC_W{1'b0}}) ? w_head_nxt : {WIDTH{1'b0}};
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_valid;
  assign o_full     = r_full;
  assign o_occ      = r_occ;

endmodule

// File: rtl/det_event_logger.sv
// Timestamps rising edges of the sequence-detector output, queues them for a
// polling reader and keeps a saturating episode count plus sticky overflow.
module det_event_logger
  import det_event_logger_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             clr,
  input  logic             rd_en,
  output logic [TS_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int OCC_W = clog2_f(DEPTH) + 1;

  logic [TS_W-1:0]  r_ts;
  logic             r_det_q;
  logic             r_overflow;
  logic [CNT_W-1:0] r_evt_cnt;

  logic             w_evt;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_cnt_sat;
  logic [OCC_W-1:0] w_occ;
  logic             w_rd_valid;
  logic             w_full;
  logic [TS_W-1:0]  w_rd_data;

  // Edge detect and push/pop/drop qualification; clr suppresses all traffic
  always_comb begin
    w_evt     = det & ~r_det_q;
    w_push    = w_evt & ~clr;
    w_pop     = rd_en & w_rd_valid & ~clr;
    w_drop    = w_push & (w_occ == OCC_W'(DEPTH)) & ~w_pop;
    w_cnt_sat = (r_evt_cnt == {CNT_W{1'b1}});
  end

  // Timestamp, edge history, overflow flag and episode counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts       <= {TS_W{1'b0}};
      r_det_q    <= 1'b0;
      r_overflow <= 1'b0;
      r_evt_cnt  <= {CNT_W{1'b0}};
    end else if (clr) begin
      // det history still tracks det, so a level held across clr is not a new episode
      r_ts       <= {TS_W{1'b0}};
      r_det_q    <= det;
      r_overflow <= 1'b0;
      r_evt_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_ts    <= r_ts + TS_W'(1);
      r_det_q <= det;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_evt && !w_cnt_sat) begin
        r_evt_cnt <= r_evt_cnt + CNT_W'(1);
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk        (clk),
    .i_reset    (reset),
    .i_clear    (clr),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wdata    (r_ts),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid),
    .o_full     (w_full),
    .o_occ      (w_occ)
  );

  assign rd_data  = w_rd_data;
  assign rd_valid = w_rd_valid;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign evt_cnt  = r_evt_cnt;

endmodule
